// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register-file widths and sequencer state encoding
package regfile_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 2;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} seq_state_e;
endpackage

// File: rtl/dump_pair_buf.sv
// dump_pair_buf: two-entry capture buffer presenting its filled slots in order
module dump_pair_buf #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load,
  input  logic [1:0]        fill,
  input  logic [1:0]        last,
  input  logic [DATA_W-1:0] d0,
  input  logic [DATA_W-1:0] d1,
  input  logic [ADDR_W-1:0] a0,
  input  logic [ADDR_W-1:0] a1,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic [ADDR_W-1:0] head_addr,
  output logic              head_valid,
  output logic              head_last,
  output logic              head_end
);
  logic [1:0][DATA_W-1:0] data_q, data_d;
  logic [1:0][ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]             last_q, last_d, vld_q, vld_d;
  logic                   head_q, head_d;
  always_comb begin
    data_d = data_q;
    addr_d = addr_q;
    last_d = last_q;
    vld_d  = vld_q;
    head_d = head_q;
    if (load) begin
      data_d = {d1, d0};
      addr_d = {a1, a0};
      last_d = last;
      vld_d  = fill;
      head_d = 1'b0;
    end else if (pop) begin
      vld_d[head_q] = 1'b0;
      head_d = 1'b1;
    end
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= '0;
      addr_q <= '0;
      last_q <= '0;
      vld_q  <= '0;
      head_q <= 1'b0;
    end else begin
      data_q <= data_d;
      addr_q <= addr_d;
      last_q <= last_d;
      vld_q  <= vld_d;
      head_q <= head_d;
    end
  end
  assign head_data  = data_q[head_q];
  assign head_addr  = addr_q[head_q];
  assign head_valid = vld_q[head_q];
  assign head_last  = last_q[head_q];
  // the head is the final word of the pair when it sits in slot 1 or slot 1 was never filled
  assign head_end   = head_q | ~vld_q[1];
endmodule

// File: rtl/regfile_dump.sv
// regfile_dump: walks a register range two reads at a time and streams words out
module regfile_dump #(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] rr1,
  output logic [ADDR_W-1:0] rr2,
  input  logic [DATA_W-1:0] rd1,
  input  logic [DATA_W-1:0] rd2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              busy,
  output logic              done
);
  import regfile_pkg::*;
  localparam logic [ADDR_W:0]   ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   TWO = (ADDR_W+1)'(2);
  localparam logic [ADDR_W-1:0] A1  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A2  = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A3  = ADDR_W'(3);
  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cur_q, cur_d, rr1_q, rr1_d, rr2_q, rr2_d;
  logic [ADDR_W:0]   rem_q, rem_d, count, taken;
  logic              hs, pair_end;
  assign count = {1'b0, last_addr - first_addr} + ONE;
  assign taken = rem_q >= TWO ? TWO : ONE;
  assign hs    = out_valid & out_ready;
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    rem_d   = rem_q;
    rr1_d   = rr1_q;
    rr2_d   = rr2_q;
    case (state_q)
      IDLE: if (start) begin
        cur_d   = first_addr;
        rem_d   = count;
        rr1_d   = first_addr;
        rr2_d   = first_addr + A1;
        state_d = FETCH;
      end
      FETCH: state_d = DRAIN;
      DRAIN: if (hs && pair_end) begin
        rem_d   = rem_q - taken;
        state_d = rem_q == taken ? DONE : FETCH;
        if (rem_q != taken) begin
          cur_d = cur_q + A2;
          rr1_d = cur_q + A2;
          rr2_d = cur_q + A3;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cur_q   <= '0;
      rem_q   <= '0;
      rr1_q   <= '0;
      rr2_q   <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      rem_q   <= rem_d;
      rr1_q   <= rr1_d;
      rr2_q   <= rr2_d;
    end
  end
  dump_pair_buf #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_buf (
    .clock      (clock),
    .reset_n    (reset_n),
    .load       (state_q == FETCH),
    .fill       (rem_q >= TWO ? 2'b11 : 2'b01),
    .last       ({rem_q == TWO, rem_q == ONE}),
    .d0         (rd1),
    .d1         (rd2),
    .a0         (rr1_q),
    .a1         (rr2_q),
    .pop        (hs),
    .head_data  (out_data),
    .head_addr  (out_addr),
    .head_valid (out_valid),
    .head_last  (out_last),
    .head_end   (pair_end)
  );
  assign rr1  = rr1_q;
  assign rr2  = rr2_q;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
endmodule
